// File: rtl/ps_serializer_if.sv
// Handshake and serial-output bundle for ps_serializer.
// The master drives the word and bit strobe; the slave returns the serial bit and status.
interface ps_serializer_if #(
  parameter int WIDTH = 4
);
  logic             cs;
  logic             clr;
  logic             load_valid;
  logic [WIDTH-1:0] p_in;
  logic             load_ready;
  logic             s;
  logic             busy;
  logic             word_done;
  logic             underrun;

  modport master (
    output cs, clr, load_valid, p_in,
    input  load_ready, s, busy, word_done, underrun
  );

  modport slave (
    input  cs, clr, load_valid, p_in,
    output load_ready, s, busy, word_done, underrun
  );
endinterface

// File: rtl/ps_serializer.sv
// Parallel-to-serial converter: one holding register feeding a shift register,
// one bit consumed per rising edge of the cs strobe, MSB first.
//
// state | meaning
// IDLE  | no word shifting; s = 0, a waiting held word is moved in on the next edge
// SHIFT | word in shift register; each cs edge consumes one bit
module ps_serializer #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  ps_serializer_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cs_b_q;
  logic             word_done_q, word_done_d;
  logic             underrun_q, underrun_d;
  logic             cs_edge;
  logic             load_fire;

  assign cs_edge   = ~cs_b_q & bus.cs;
  assign load_fire = bus.load_valid & ~hold_full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sreg_q      <= '0;
      cnt_q       <= '0;
      cs_b_q      <= 1'b1;
      word_done_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      cs_b_q      <= bus.cs;
      word_done_q <= word_done_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    word_done_d = 1'b0;
    underrun_d  = 1'b0;

    if (bus.clr) begin
      state_d     = IDLE;
      hold_full_d = 1'b0;
      sreg_d      = '0;
      cnt_d       = '0;
    end else begin
      // Capture needs an empty holder and a transfer needs a full one, so the
      // two hold_full updates below never collide on the same edge.
      if (load_fire) begin
        hold_d      = bus.p_in;
        hold_full_d = 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (cs_edge) begin
            underrun_d = 1'b1;
          end
          if (hold_full_q) begin
            sreg_d      = hold_q;
            hold_full_d = 1'b0;
            cnt_d       = '0;
            state_d     = SHIFT;
          end
        end
        SHIFT: begin
          if (cs_edge) begin
            if (cnt_q == LAST) begin
              word_done_d = 1'b1;
              if (hold_full_q) begin
                sreg_d      = hold_q;
                hold_full_d = 1'b0;
                cnt_d       = '0;
              end else begin
                sreg_d  = '0;
                state_d = IDLE;
              end
            end else begin
              sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
              cnt_d  = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.s          = sreg_q[WIDTH-1];
  assign bus.busy       = (state_q == SHIFT);
  assign bus.load_ready = ~hold_full_q;
  assign bus.word_done  = word_done_q;
  assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_ps_serializer.sv
// Directed bench for ps_serializer at WIDTH=4; inputs change 1 ns after a rising
// edge and outputs are read at that point, well clear of the next edge.
module tb_ps_serializer;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ps_serializer_if #(.WIDTH(4)) bus ();

  ps_serializer #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.cs = 1'b0; bus.clr = 1'b0; bus.load_valid = 1'b0; bus.p_in = 4'h0;
    #3;
    total++; if (bus.s !== 1'b0)          begin bad++; $display("FAIL reset_s: got %b want 0", bus.s); end
    total++; if (bus.load_ready !== 1'b1) begin bad++; $display("FAIL reset_load_ready: got %b want 1", bus.load_ready); end
    total++; if (bus.busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.word_done !== 1'b0)  begin bad++; $display("FAIL reset_word_done: got %b want 0", bus.word_done); end
    total++; if (bus.underrun !== 1'b0)   begin bad++; $display("FAIL reset_underrun: got %b want 0", bus.underrun); end
    tick; tick;
    rst_n = 1'b1;
    tick; tick;
    total++; if (bus.busy !== 1'b0 || bus.load_ready !== 1'b1) begin bad++; $display("FAIL post_reset: busy=%b load_ready=%b want 0 1", bus.busy, bus.load_ready); end
  endtask

  task automatic test_basic;
    logic [3:0] w;
    w = 4'b1011;
    bus.load_valid = 1'b1; bus.p_in = w;
    tick;
    bus.load_valid = 1'b0;
    total++; if (bus.load_ready !== 1'b0) begin bad++; $display("FAIL basic_captured: load_ready=%b want 0", bus.load_ready); end
    tick;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy_start: got %b want 1", bus.busy); end
    for (int i = 0; i < 4; i++) begin
      bus.cs = 1'b1;
      total++; if (bus.s !== w[3-i]) begin bad++; $display("FAIL basic_bit%0d: s=%b want %b", i, bus.s, w[3-i]); end
      tick;
      total++; if (bus.word_done !== (i == 3)) begin bad++; $display("FAIL basic_word_done%0d: got %b want %b", i, bus.word_done, (i == 3)); end
      total++; if (bus.busy !== (i != 3))      begin bad++; $display("FAIL basic_busy%0d: got %b want %b", i, bus.busy, (i != 3)); end
      bus.cs = 1'b0;
      tick;
    end
    total++; if (bus.word_done !== 1'b0 || bus.load_ready !== 1'b1 || bus.s !== 1'b0)
      begin bad++; $display("FAIL basic_end: word_done=%b load_ready=%b s=%b want 0 1 0", bus.word_done, bus.load_ready, bus.s); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_bits;
    int         pulses;
    exp_bits = 8'b1010_0101;
    pulses   = 0;
    bus.load_valid = 1'b1; bus.p_in = 4'hA;
    tick;
    bus.load_valid = 1'b0;
    tick;
    for (int i = 0; i < 8; i++) begin
      bus.cs = 1'b1;
      total++; if (bus.s !== exp_bits[7-i]) begin bad++; $display("FAIL b2b_bit%0d: s=%b want %b", i, bus.s, exp_bits[7-i]); end
      total++; if (bus.busy !== 1'b1)       begin bad++; $display("FAIL b2b_busy%0d: got %b want 1", i, bus.busy); end
      tick;
      if (bus.word_done === 1'b1) pulses++;
      total++; if (bus.load_ready !== !(i == 1 || i == 2)) begin bad++; $display("FAIL b2b_load_ready%0d: got %b want %b", i, bus.load_ready, !(i == 1 || i == 2)); end
      bus.cs = 1'b0;
      if (i == 0) begin
        bus.load_valid = 1'b1; bus.p_in = 4'h5;
      end
      tick;
      bus.load_valid = 1'b0;
      total++; if (bus.word_done !== 1'b0) begin bad++; $display("FAIL b2b_wd_width%0d: got %b want 0", i, bus.word_done); end
    end
    total++; if (pulses !== 2)      begin bad++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end: got %b want 0", bus.busy); end
  endtask

  task automatic test_underrun;
    logic [3:0] w;
    bus.cs = 1'b1;
    tick;
    total++; if (bus.underrun !== 1'b1 || bus.s !== 1'b0 || bus.busy !== 1'b0 || bus.word_done !== 1'b0)
      begin bad++; $display("FAIL ur_pulse: underrun=%b s=%b busy=%b wd=%b want 1 0 0 0", bus.underrun, bus.s, bus.busy, bus.word_done); end
    bus.cs = 1'b0;
    tick;
    total++; if (bus.underrun !== 1'b0) begin bad++; $display("FAIL ur_one_cycle: got %b want 0", bus.underrun); end
    // cs held high across many cycles must consume only the first bit.
    w = 4'b1010;
    bus.load_valid = 1'b1; bus.p_in = w;
    tick;
    bus.load_valid = 1'b0;
    tick;
    bus.cs = 1'b1;
    for (int i = 0; i < 10; i++) tick;
    total++; if (bus.s !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL held_cs: s=%b busy=%b want 0 1", bus.s, bus.busy); end
    bus.cs = 1'b0;
    tick;
    for (int i = 1; i < 4; i++) begin
      bus.cs = 1'b1;
      total++; if (bus.s !== w[3-i]) begin bad++; $display("FAIL held_rest_bit%0d: s=%b want %b", i, bus.s, w[3-i]); end
      tick;
      total++; if (bus.word_done !== (i == 3)) begin bad++; $display("FAIL held_wd%0d: got %b want %b", i, bus.word_done, (i == 3)); end
      bus.cs = 1'b0;
      tick;
    end
  endtask

  task automatic test_clear;
    logic [3:0] w;
    bus.load_valid = 1'b1; bus.p_in = 4'hF;
    tick;
    bus.load_valid = 1'b0;
    tick;
    for (int i = 0; i < 2; i++) begin
      bus.cs = 1'b1; tick;
      bus.cs = 1'b0; tick;
    end
    bus.clr = 1'b1;
    tick;
    bus.clr = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.s !== 1'b0 || bus.load_ready !== 1'b1 || bus.word_done !== 1'b0)
      begin bad++; $display("FAIL clr: busy=%b s=%b load_ready=%b wd=%b want 0 0 1 0", bus.busy, bus.s, bus.load_ready, bus.word_done); end
    w = 4'h8;
    bus.load_valid = 1'b1; bus.p_in = w;
    tick;
    bus.load_valid = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      bus.cs = 1'b1;
      total++; if (bus.s !== w[3-i]) begin bad++; $display("FAIL clr_new_bit%0d: s=%b want %b", i, bus.s, w[3-i]); end
      tick;
      total++; if (bus.word_done !== (i == 3)) begin bad++; $display("FAIL clr_new_wd%0d: got %b want %b", i, bus.word_done, (i == 3)); end
      bus.cs = 1'b0;
      tick;
    end
  endtask

  task automatic test_late_load;
    logic [3:0] w;
    // A word captured on the end-of-word edge goes via IDLE, not a direct reload.
    bus.load_valid = 1'b1; bus.p_in = 4'hC;
    tick;
    bus.load_valid = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) begin
      bus.cs = 1'b1; tick;
      bus.cs = 1'b0; tick;
    end
    bus.cs = 1'b1; bus.load_valid = 1'b1; bus.p_in = 4'h3;
    tick;
    bus.load_valid = 1'b0; bus.cs = 1'b0;
    total++; if (bus.word_done !== 1'b1 || bus.busy !== 1'b0 || bus.load_ready !== 1'b0)
      begin bad++; $display("FAIL late_eow: wd=%b busy=%b load_ready=%b want 1 0 0", bus.word_done, bus.busy, bus.load_ready); end
    tick;
    total++; if (bus.busy !== 1'b1 || bus.s !== 1'b0 || bus.load_ready !== 1'b1)
      begin bad++; $display("FAIL late_move: busy=%b s=%b load_ready=%b want 1 0 1", bus.busy, bus.s, bus.load_ready); end
    w = 4'h3;
    for (int i = 0; i < 4; i++) begin
      bus.cs = 1'b1;
      total++; if (bus.s !== w[3-i]) begin bad++; $display("FAIL late_bit%0d: s=%b want %b", i, bus.s, w[3-i]); end
      tick;
      bus.cs = 1'b0;
      tick;
    end
    // cs edge on the IDLE->SHIFT transfer edge underruns and does not consume.
    w = 4'h9;
    bus.load_valid = 1'b1; bus.p_in = w;
    tick;
    bus.load_valid = 1'b0;
    bus.cs = 1'b1;
    tick;
    bus.cs = 1'b0;
    total++; if (bus.underrun !== 1'b1 || bus.busy !== 1'b1 || bus.s !== 1'b1)
      begin bad++; $display("FAIL move_ur: underrun=%b busy=%b s=%b want 1 1 1", bus.underrun, bus.busy, bus.s); end
    tick;
    for (int i = 0; i < 4; i++) begin
      bus.cs = 1'b1;
      total++; if (bus.s !== w[3-i]) begin bad++; $display("FAIL move_bit%0d: s=%b want %b", i, bus.s, w[3-i]); end
      tick;
      total++; if (bus.word_done !== (i == 3)) begin bad++; $display("FAIL move_wd%0d: got %b want %b", i, bus.word_done, (i == 3)); end
      bus.cs = 1'b0;
      tick;
    end
  endtask

  task automatic test_reset_mid_word;
    bus.load_valid = 1'b1; bus.p_in = 4'b1001;
    tick;
    bus.load_valid = 1'b0;
    tick;
    bus.cs = 1'b1; tick;
    bus.cs = 1'b0; tick;
    bus.cs = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.s !== 1'b0 || bus.load_ready !== 1'b1 || bus.busy !== 1'b0 || bus.word_done !== 1'b0 || bus.underrun !== 1'b0)
      begin bad++; $display("FAIL midrst_in_reset: s=%b lr=%b busy=%b wd=%b ur=%b want 0 1 0 0 0", bus.s, bus.load_ready, bus.busy, bus.word_done, bus.underrun); end
    tick; tick;
    #2 rst_n = 1'b1;
    tick;
    total++; if (bus.underrun !== 1'b0 || bus.busy !== 1'b0 || bus.s !== 1'b0)
      begin bad++; $display("FAIL midrst_release: ur=%b busy=%b s=%b want 0 0 0", bus.underrun, bus.busy, bus.s); end
    bus.load_valid = 1'b1; bus.p_in = 4'b1001;
    tick;
    bus.load_valid = 1'b0;
    tick;
    total++; if (bus.busy !== 1'b1 || bus.s !== 1'b1 || bus.underrun !== 1'b0)
      begin bad++; $display("FAIL midrst_reload: busy=%b s=%b ur=%b want 1 1 0", bus.busy, bus.s, bus.underrun); end
    tick; tick; tick;
    total++; if (bus.s !== 1'b1) begin bad++; $display("FAIL midrst_no_shift: s=%b want 1", bus.s); end
    bus.cs = 1'b0;
    tick;
    bus.cs = 1'b1;
    tick;
    total++; if (bus.s !== 1'b0) begin bad++; $display("FAIL midrst_new_edge: s=%b want 0", bus.s); end
    bus.cs = 1'b0;
    bus.clr = 1'b1;
    tick;
    bus.clr = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_underrun;
    test_clear;
    test_late_load;
    test_reset_mid_word;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
